// File: rtl/ssm2603_i2s_pkg.sv
// Shared defaults and the sample-pair type for the SSM2603 I2S codec stand-in.
package ssm2603_i2s_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_SLOT_BITS  = 32;
  localparam int DEF_BCLK_DIV   = 4;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] left;
    logic [DEF_DATA_WIDTH-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk into bclk and tracks the bit position
// within the stereo frame. rise_o/fall_o flag the clk edge on which bclk
// changes; bit_cnt_next_o is the value bit_cnt takes on a fall event.
module i2s_bclk_gen
  import ssm2603_i2s_pkg::*;
#(
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int BCLK_DIV  = DEF_BCLK_DIV,
  localparam int CNT_W    = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic             bclk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_next_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT_BITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             toggle;
  logic [CNT_W-1:0] bit_cnt_inc;

  assign toggle      = (div_cnt_q == DIV_LAST);
  assign bit_cnt_inc = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);

  assign rise_o         = toggle & ~bclk_q;
  assign fall_o         = toggle & bclk_q;
  assign bclk_o         = bclk_q;
  assign bit_cnt_o      = bit_cnt_q;
  assign bit_cnt_next_o = bit_cnt_inc;

  // Next-state: divider wraps and toggles bclk; bit position advances on falls.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    if (toggle) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        bit_cnt_d = bit_cnt_inc;
      end
    end
  end

  // State registers; bit_cnt starts at the last position so the first fall opens frame 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/ssm2603_i2s_master.sv
// SSM2603-side I2S clock master: drives bclk and the LR clocks, serializes ADC
// pairs onto adc_dat (I2S, one bclk after the LR edge) and captures DAC pairs
// from dac_dat. A one-deep holding register decouples the ADC handshake from
// the frame boundary.
module ssm2603_i2s_master
  import ssm2603_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_BITS  = DEF_SLOT_BITS,
  parameter int BCLK_DIV   = DEF_BCLK_DIV
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic                  bclk_o,
  output logic                  pblrc_o,
  output logic                  reclrc_o,
  output logic                  adc_dat_o,
  input  logic                  dac_dat_i,
  input  logic [DATA_WIDTH-1:0] adc_left_i,
  input  logic [DATA_WIDTH-1:0] adc_right_i,
  input  logic                  adc_valid_i,
  output logic                  adc_ready_o,
  output logic [DATA_WIDTH-1:0] dac_left_o,
  output logic [DATA_WIDTH-1:0] dac_right_o,
  output logic                  dac_valid_o,
  output logic                  adc_underrun_o
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] DW_C     = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT_BITS - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  logic             rise, fall;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;

  i2s_bclk_gen #(
    .SLOT_BITS(SLOT_BITS),
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .bclk_o        (bclk_o),
    .rise_o        (rise),
    .fall_o        (fall),
    .bit_cnt_o     (bit_cnt),
    .bit_cnt_next_o(bit_cnt_next)
  );

  pair_t hold_q, hold_d, shift_q, shift_d, cap_q, cap_d, dac_q, dac_d;
  logic  ready_q, ready_d;
  logic  dac_valid_q, dac_valid_d;
  logic  underrun_q, underrun_d;
  logic  adc_dat_q, adc_dat_d;
  logic  lrc_q, lrc_d;
  logic  started_q, started_d;

  // Slot decode for the current position (rise) and the upcoming one (fall).
  logic             cur_right, nxt_right, cur_in_data, nxt_in_data, frame_start;
  logic [CNT_W-1:0] cur_k, nxt_k;
  logic [IDX_W-1:0] nxt_idx;

  assign cur_right   = (bit_cnt >= SLOT_C);
  assign cur_k       = cur_right ? (bit_cnt - SLOT_C) : bit_cnt;
  assign cur_in_data = (cur_k != '0) && (cur_k <= DW_C);
  assign nxt_right   = (bit_cnt_next >= SLOT_C);
  assign nxt_k       = nxt_right ? (bit_cnt_next - SLOT_C) : bit_cnt_next;
  assign nxt_in_data = (nxt_k != '0) && (nxt_k <= DW_C);
  assign nxt_idx     = IDX_W'(DW_C - nxt_k);
  assign frame_start = fall && (bit_cnt_next == '0);

  // Handshake, frame-start reload, serializer and capture next-state.
  always_comb begin
    hold_d      = hold_q;
    ready_d     = ready_q;
    shift_d     = shift_q;
    cap_d       = cap_q;
    dac_d       = dac_q;
    dac_valid_d = 1'b0;
    underrun_d  = 1'b0;
    adc_dat_d   = adc_dat_q;
    lrc_d       = lrc_q;
    started_d   = started_q;

    // The frame consumes the holding register as it stood before this edge.
    if (frame_start) begin
      started_d = 1'b1;
      if (!ready_q) begin
        shift_d = hold_q;
        ready_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // Accept only when empty, so this never collides with the reload above.
    if (adc_valid_i && ready_q) begin
      hold_d.left  = adc_left_i;
      hold_d.right = adc_right_i;
      ready_d      = 1'b0;
    end

    if (fall) begin
      lrc_d     = nxt_right;
      adc_dat_d = 1'b0;
      if (nxt_in_data) begin
        adc_dat_d = nxt_right ? shift_q.right[nxt_idx] : shift_q.left[nxt_idx];
      end
    end

    if (rise) begin
      if (cur_in_data) begin
        if (cur_right) cap_d.right = {cap_q.right[DATA_WIDTH-2:0], dac_dat_i};
        else           cap_d.left  = {cap_q.left[DATA_WIDTH-2:0], dac_dat_i};
      end
      // Last rise of the frame: the pair is complete, unless no frame has begun yet.
      if ((bit_cnt == BIT_LAST) && started_q) begin
        dac_d       = cap_q;
        dac_valid_d = 1'b1;
      end
    end
  end

  // Registers; reset discards any partially captured pair.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q      <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      dac_q       <= '0;
      ready_q     <= 1'b1;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      adc_dat_q   <= 1'b0;
      lrc_q       <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      dac_q       <= dac_d;
      ready_q     <= ready_d;
      dac_valid_q <= dac_valid_d;
      underrun_q  <= underrun_d;
      adc_dat_q   <= adc_dat_d;
      lrc_q       <= lrc_d;
      started_q   <= started_d;
    end
  end

  assign pblrc_o        = lrc_q;
  assign reclrc_o       = lrc_q;
  assign adc_dat_o      = adc_dat_q;
  assign adc_ready_o    = ready_q;
  assign dac_left_o     = dac_q.left;
  assign dac_right_o    = dac_q.right;
  assign dac_valid_o    = dac_valid_q;
  assign adc_underrun_o = underrun_q;

endmodule

// File: tb/tb_ssm2603_i2s_master.sv
// Loopback bench: dac_dat is tied to adc_dat, random ADC pairs are offered
// under several valid policies, and every output is compared each cycle with
// a timing model derived from clk-edge arithmetic plus a queue for holding.
module tb_ssm2603_i2s_master;
  import ssm2603_i2s_pkg::*;

  localparam int DW = 24;
  localparam int SB = 32;
  localparam int BD = 2;
  localparam int P  = 2 * BD;       // clk cycles per bclk period
  localparam int FR = 2 * SB * P;   // clk cycles per frame

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          bclk_o, pblrc_o, reclrc_o, adc_dat_o, dac_dat_i;
  logic [DW-1:0] adc_left_i, adc_right_i, dac_left_o, dac_right_o;
  logic          adc_valid_i, adc_ready_o, dac_valid_o, adc_underrun_o;

  always #5 clk_i = ~clk_i;
  assign dac_dat_i = adc_dat_o;

  ssm2603_i2s_master #(
    .DATA_WIDTH(DW),
    .SLOT_BITS (SB),
    .BCLK_DIV  (BD)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .bclk_o        (bclk_o),
    .pblrc_o       (pblrc_o),
    .reclrc_o      (reclrc_o),
    .adc_dat_o     (adc_dat_o),
    .dac_dat_i     (dac_dat_i),
    .adc_left_i    (adc_left_i),
    .adc_right_i   (adc_right_i),
    .adc_valid_i   (adc_valid_i),
    .adc_ready_o   (adc_ready_o),
    .dac_left_o    (dac_left_o),
    .dac_right_o   (dac_right_o),
    .dac_valid_o   (dac_valid_o),
    .adc_underrun_o(adc_underrun_o)
  );

  int total = 0;
  int bad   = 0;

  // Model state: t = clk edges since reset release.
  int           t;
  sample_pair_t cur, offer, last_dac;
  sample_pair_t hold_m[$];
  sample_pair_t frame_pair[32];
  bit           exp_underrun, exp_dv, need_new;
  int           epoch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic int cur_frame();
    int nf;
    nf = t / P;
    return (nf == 0) ? -1 : (nf - 1) / (2 * SB);
  endfunction

  function automatic int bit_pos();
    int nf;
    nf = t / P;
    return (nf == 0) ? 2 * SB - 1 : (nf - 1) % (2 * SB);
  endfunction

  function automatic logic exp_adc();
    int b, k;
    logic [DW-1:0] w;
    if (t / P == 0) return 1'b0;
    b = bit_pos();
    k = b % SB;
    w = (b >= SB) ? cur.right : cur.left;
    if (k >= 1 && k <= DW) return w[DW-k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    t = 0;
    cur = '0;
    last_dac = '0;
    hold_m.delete();
    exp_underrun = 1'b0;
    exp_dv = 1'b0;
  endtask

  task automatic model_edge(input bit acc);
    int f;
    t++;
    exp_underrun = 1'b0;
    exp_dv = 1'b0;
    if (t % P == 0 && ((t / P - 1) % (2 * SB)) == 0) begin
      f = (t / P - 1) / (2 * SB);
      if (hold_m.size() > 0) cur = hold_m.pop_front();
      else exp_underrun = 1'b1;
      frame_pair[f] = cur;
    end
    if (acc) hold_m.push_back(offer);
    if (t >= FR + BD && (t - BD) % FR == 0) begin
      exp_dv = 1'b1;
      last_dac = frame_pair[(t - BD) / FR - 1];
    end
  endtask

  task automatic check_outputs();
    logic lr;
    lr = (t / P == 0) ? 1'b0 : (bit_pos() >= SB);
    check("bclk", 32'(bclk_o), 32'((t / BD) % 2));
    check("pblrc", 32'(pblrc_o), 32'(lr));
    check("reclrc", 32'(reclrc_o), 32'(lr));
    check("adc_dat", 32'(adc_dat_o), 32'(exp_adc()));
    check("adc_ready", 32'(adc_ready_o), 32'(hold_m.size() == 0));
    check("underrun", 32'(adc_underrun_o), 32'(exp_underrun));
    check("dac_valid", 32'(dac_valid_o), 32'(exp_dv));
    check("dac_left", 32'(dac_left_o), 32'(last_dac.left));
    check("dac_right", 32'(dac_right_o), 32'(last_dac.right));
    if (exp_dv)
      $display("rx epoch=%0d t=%0d left=%h right=%h", epoch, t, dac_left_o, dac_right_o);
  endtask

  task automatic step();
    int cf;
    logic v;
    bit acc;
    logic [31:0] r1, r2;
    cf = cur_frame();
    if (need_new) begin
      r1 = $urandom;
      r2 = $urandom;
      offer.left  = r1[DW-1:0];
      offer.right = r2[DW-1:0];
      need_new = 1'b0;
    end
    if (epoch == 2)   v = 1'b1;
    else if (cf <= 8) v = 1'b1;                              // backpressure
    else if (cf <= 11) v = (t + 1 == P * (1 + 2 * SB * 12)); // underrun, then accept on frame start
    else              v = ($urandom_range(0, 3) == 0);
    adc_valid_i = v;
    adc_left_i  = offer.left;
    adc_right_i = offer.right;
    acc = v && (hold_m.size() == 0);
    @(posedge clk_i);
    model_edge(acc);
    if (acc) need_new = 1'b1;
    @(negedge clk_i);
    check_outputs();
  endtask

  initial begin
    bit reset_done;
    reset_i     = 1'b1;
    adc_valid_i = 1'b0;
    adc_left_i  = '0;
    adc_right_i = '0;
    epoch       = 1;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_outputs();

    offer.left  = 24'hA5F00F;
    offer.right = 24'h5A0FF0;
    need_new    = 1'b0;
    reset_i     = 1'b0;

    reset_done = 1'b0;
    for (int c = 0; c < 20 * FR && !reset_done; c++) begin
      step();
      if (cur_frame() == 16 && bit_pos() == 40) begin
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i);
          check("dac_valid_in_reset", 32'(dac_valid_o), 32'd0);
        end
        reset_i    = 1'b0;
        reset_done = 1'b1;
      end
    end
    check("reset_trigger", 32'(reset_done), 32'd1);

    epoch    = 2;
    need_new = 1'b1;
    for (int c = 0; c < 5 * FR && cur_frame() < 3; c++) step();
    check("epoch2_frames", 32'(cur_frame()), 32'd3);

    adc_valid_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
